// File: rtl/dram_slot_sched_pkg.sv
// Shared types for the DRAM slot scheduler: slot owner encoding and the
// command word handed to the RAS/CAS sequencer.
package dram_slot_sched_pkg;
  localparam int DRAM_AW = 21;
  localparam int DRAM_DW = 16;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2,
    OWN_RFSH = 2'd3
  } owner_e;

  typedef struct packed {
    logic               rfsh;
    logic               rnw;
    logic [DRAM_AW-1:0] addr;
    logic [1:0]         bsel;
    logic [DRAM_DW-1:0] wrdata;
  } dc_cmd_t;
endpackage

// File: rtl/dram_rfsh_timer.sv
// Refresh interval timer with a saturating count of refreshes still owed.
module dram_rfsh_timer #(
  parameter int RFSH_PERIOD = 438,
  parameter int RFSH_URGENT = 4
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       rfsh_grant,
  output logic [2:0] pending,
  output logic       urgent
);
  localparam int TW = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;

  logic [TW-1:0] timer;
  logic          tick;

  assign tick   = (timer == TW'(RFSH_PERIOD - 1));
  assign urgent = (pending >= 3'(RFSH_URGENT));

  always_ff @(posedge fclk) begin
    if (rst) begin
      timer   <= '0;
      pending <= '0;
    end else begin
      timer <= tick ? '0 : timer + TW'(1);
      // a tick landing on a grant cancels out
      unique case ({tick, rfsh_grant})
        2'b10:   if (pending != 3'd7) pending <= pending + 3'd1;
        2'b01:   if (pending != 3'd0) pending <= pending - 3'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dram_slot_sched.sv
// Fixed-length DRAM slot scheduler: arbitrates CPU, video and refresh at the
// last phase of each slot and issues one sequencer command per owned slot.
module dram_slot_sched
  import dram_slot_sched_pkg::*;
#(
  parameter int SLOT_LEN     = 4,
  parameter int RFSH_PERIOD  = 438,
  parameter int RFSH_URGENT  = 4,
  parameter int CPU_MAX_WAIT = 3
) (
  input  logic                fclk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_rnw,
  input  logic [DRAM_AW-1:0]  cpu_addr,
  input  logic [1:0]          cpu_bsel,
  input  logic [DRAM_DW-1:0]  cpu_wrdata,
  output logic                cpu_ack,
  output logic                cpu_rdstb,
  input  logic                vid_req,
  input  logic [DRAM_AW-1:0]  vid_addr,
  output logic                vid_ack,
  output logic                vid_rdstb,
  output logic                dc_start,
  output logic                dc_rfsh,
  output logic                dc_rnw,
  output logic [DRAM_AW-1:0]  dc_addr,
  output logic [1:0]          dc_bsel,
  output logic [DRAM_DW-1:0]  dc_wrdata,
  input  logic [DRAM_DW-1:0]  dc_rddata,
  output logic [1:0]          slot_owner
);
  localparam int PW = $clog2(SLOT_LEN);
  localparam int WW = $clog2(CPU_MAX_WAIT + 1);

  logic [PW-1:0] phase;
  logic [WW-1:0] cpu_wait;
  logic          last, pre_last, cpu_starved;
  logic [2:0]    pending;
  logic          urgent, rfsh_grant;
  owner_e        owner, winner;
  dc_cmd_t       cmd;

  // read data is wired straight to the requesters; only the strobes come from here
  logic unused_rd;
  assign unused_rd = ^dc_rddata;

  assign last        = (phase == PW'(SLOT_LEN - 1));
  assign pre_last    = (phase == PW'(SLOT_LEN - 2));
  assign cpu_starved = (cpu_wait >= WW'(CPU_MAX_WAIT));
  assign rfsh_grant  = last && (winner == OWN_RFSH);

  dram_rfsh_timer #(.RFSH_PERIOD(RFSH_PERIOD), .RFSH_URGENT(RFSH_URGENT)) u_rt (
    .fclk(fclk), .rst(rst), .rfsh_grant(rfsh_grant), .pending(pending), .urgent(urgent)
  );

  always_comb begin
    winner = OWN_IDLE;
    if (urgent)                     winner = OWN_RFSH;
    else if (cpu_req && cpu_starved) winner = OWN_CPU;
    else if (vid_req)               winner = OWN_VID;
    else if (cpu_req)               winner = OWN_CPU;
    else if (pending != 3'd0)       winner = OWN_RFSH;
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      phase     <= '0;
      owner     <= OWN_IDLE;
      cpu_wait  <= '0;
      cmd       <= '0;
      dc_start  <= 1'b0;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_rdstb <= 1'b0;
      vid_rdstb <= 1'b0;
    end else begin
      phase     <= last ? '0 : phase + PW'(1);
      dc_start  <= 1'b0;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_rdstb <= pre_last && (owner == OWN_CPU) && cmd.rnw;
      vid_rdstb <= pre_last && (owner == OWN_VID);
      if (last) begin
        owner    <= winner;
        dc_start <= (winner != OWN_IDLE);
        if (cpu_req && winner != OWN_CPU)
          cpu_wait <= cpu_starved ? cpu_wait : cpu_wait + WW'(1);
        else
          cpu_wait <= '0;
        // idle slots keep the previous command on the bus
        unique case (winner)
          OWN_CPU: begin
            cmd     <= '{rfsh: 1'b0, rnw: cpu_rnw, addr: cpu_addr, bsel: cpu_bsel, wrdata: cpu_wrdata};
            cpu_ack <= 1'b1;
          end
          OWN_VID: begin
            cmd     <= '{rfsh: 1'b0, rnw: 1'b1, addr: vid_addr, bsel: 2'b11, wrdata: '0};
            vid_ack <= 1'b1;
          end
          OWN_RFSH: cmd <= '{rfsh: 1'b1, default: '0};
          default:  ;
        endcase
      end
    end
  end

  assign dc_rfsh    = cmd.rfsh;
  assign dc_rnw     = cmd.rnw;
  assign dc_addr    = cmd.addr;
  assign dc_bsel    = cmd.bsel;
  assign dc_wrdata  = cmd.wrdata;
  assign slot_owner = owner;
endmodule

// File: tb/tb_dram_slot_sched.sv
// Directed bench for dram_slot_sched: one scheduler at default timing plus two
// sharing its stimulus with short refresh periods for urgency and saturation.
module tb_dram_slot_sched;
  logic        fclk, rst;
  logic        cpu_req, cpu_rnw;
  logic [20:0] cpu_addr, vid_addr;
  logic [1:0]  cpu_bsel;
  logic [15:0] cpu_wrdata, dc_rddata;
  logic        vid_req;

  logic        a_cpu_ack, a_cpu_rdstb, a_vid_ack, a_vid_rdstb, a_dc_start, a_dc_rfsh, a_dc_rnw;
  logic [20:0] a_dc_addr;
  logic [1:0]  a_dc_bsel, a_slot_owner;
  logic [15:0] a_dc_wrdata;
  logic        b_cpu_ack, b_cpu_rdstb, b_vid_ack, b_vid_rdstb, b_dc_start, b_dc_rfsh, b_dc_rnw;
  logic [20:0] b_dc_addr;
  logic [1:0]  b_dc_bsel, b_slot_owner;
  logic [15:0] b_dc_wrdata;
  logic        c_cpu_ack, c_cpu_rdstb, c_vid_ack, c_vid_rdstb, c_dc_start, c_dc_rfsh, c_dc_rnw;
  logic [20:0] c_dc_addr;
  logic [1:0]  c_dc_bsel, c_slot_owner;
  logic [15:0] c_dc_wrdata;

  int errors = 0;
  int checks = 0;
  int t = 0;

  dram_slot_sched u_a (
    .fclk(fclk), .rst(rst), .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_bsel(cpu_bsel), .cpu_wrdata(cpu_wrdata), .cpu_ack(a_cpu_ack), .cpu_rdstb(a_cpu_rdstb),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(a_vid_ack), .vid_rdstb(a_vid_rdstb),
    .dc_start(a_dc_start), .dc_rfsh(a_dc_rfsh), .dc_rnw(a_dc_rnw), .dc_addr(a_dc_addr),
    .dc_bsel(a_dc_bsel), .dc_wrdata(a_dc_wrdata), .dc_rddata(dc_rddata), .slot_owner(a_slot_owner)
  );

  dram_slot_sched #(.RFSH_PERIOD(16)) u_b (
    .fclk(fclk), .rst(rst), .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_bsel(cpu_bsel), .cpu_wrdata(cpu_wrdata), .cpu_ack(b_cpu_ack), .cpu_rdstb(b_cpu_rdstb),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(b_vid_ack), .vid_rdstb(b_vid_rdstb),
    .dc_start(b_dc_start), .dc_rfsh(b_dc_rfsh), .dc_rnw(b_dc_rnw), .dc_addr(b_dc_addr),
    .dc_bsel(b_dc_bsel), .dc_wrdata(b_dc_wrdata), .dc_rddata(dc_rddata), .slot_owner(b_slot_owner)
  );

  // two ticks per slot: pending can only climb, so it must pin at 7
  dram_slot_sched #(.RFSH_PERIOD(2)) u_c (
    .fclk(fclk), .rst(rst), .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_bsel(cpu_bsel), .cpu_wrdata(cpu_wrdata), .cpu_ack(c_cpu_ack), .cpu_rdstb(c_cpu_rdstb),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(c_vid_ack), .vid_rdstb(c_vid_rdstb),
    .dc_start(c_dc_start), .dc_rfsh(c_dc_rfsh), .dc_rnw(c_dc_rnw), .dc_addr(c_dc_addr),
    .dc_bsel(c_dc_bsel), .dc_wrdata(c_dc_wrdata), .dc_rddata(dc_rddata), .slot_owner(c_slot_owner)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge fclk);
    t++;
  endtask

  task automatic goto(input int x);
    while (t < x) step();
  endtask

  int exp_own[9] = '{2, 2, 2, 1, 2, 2, 2, 1, 2};

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_bsel = '0;
    cpu_wrdata = '0; vid_req = 1'b0; vid_addr = '0; dc_rddata = 16'hBEEF;
    repeat (3) @(negedge fclk);
    chk("reset_ctl", {a_dc_start, a_cpu_ack, a_vid_ack, a_cpu_rdstb, a_vid_rdstb, a_slot_owner}, 0);
    chk("reset_cmd", {a_dc_rfsh, a_dc_rnw, a_dc_addr, a_dc_bsel, a_dc_wrdata}, 0);

    // idle: nothing requested, refresh timer far from a tick
    rst = 1'b0; t = 0;
    for (int i = 0; i < 40; i++) begin
      chk("idle", {a_dc_start, a_cpu_ack, a_vid_ack, a_cpu_rdstb, a_vid_rdstb, a_slot_owner}, 0);
      step();
    end

    // CPU read presented at phase 3
    goto(43);
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h12345; cpu_bsel = 2'b11;
    goto(44);
    chk("rd_ack", a_cpu_ack, 1);
    chk("rd_start", a_dc_start, 1);
    chk("rd_addr", a_dc_addr, 21'h12345);
    chk("rd_bsel_rnw", {a_dc_bsel, a_dc_rnw, a_dc_rfsh}, {2'b11, 1'b1, 1'b0});
    chk("rd_owner", a_slot_owner, 1);
    cpu_req = 1'b0;
    goto(45);
    chk("rd_ack_pulse", {a_cpu_ack, a_dc_start}, 0);
    goto(46);
    chk("rd_stb_early", a_cpu_rdstb, 0);
    goto(47);
    chk("rd_stb", a_cpu_rdstb, 1);

    // contention: CPU write against continuous video
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 21'h1F00F; cpu_bsel = 2'b01; cpu_wrdata = 16'h5A5A;
    vid_req = 1'b1; vid_addr = 21'h0ABCD;
    for (int s = 0; s < 9; s++) begin
      goto(48 + 4 * s);
      chk("ct_owner", a_slot_owner, exp_own[s]);
      chk("ct_start", a_dc_start, 1);
      if (exp_own[s] == 2) begin
        chk("ct_vid_ack", {a_vid_ack, a_cpu_ack}, 2'b10);
        chk("ct_vid_cmd", {a_dc_addr, a_dc_bsel, a_dc_rnw}, {21'h0ABCD, 2'b11, 1'b1});
      end else begin
        chk("ct_cpu_ack", {a_vid_ack, a_cpu_ack}, 2'b01);
        chk("ct_cpu_cmd", {a_dc_addr, a_dc_bsel, a_dc_rnw, a_dc_wrdata}, {21'h1F00F, 2'b01, 1'b0, 16'h5A5A});
      end
      goto(51 + 4 * s);
      chk("ct_vid_stb", a_vid_rdstb, (exp_own[s] == 2) ? 1 : 0);
      chk("ct_cpu_stb", a_cpu_rdstb, 0);
    end
    goto(84);
    chk("ct_owner_after", a_slot_owner, 2);

    // reset in phase 1 of a video slot
    goto(85);
    rst = 1'b1; cpu_req = 1'b0;
    step();
    chk("mr_ctl", {a_dc_start, a_cpu_ack, a_vid_ack, a_cpu_rdstb, a_vid_rdstb, a_slot_owner}, 0);
    chk("mr_cmd", {a_dc_rfsh, a_dc_rnw, a_dc_addr, a_dc_bsel, a_dc_wrdata}, 0);
    step();
    step();
    chk("mr_no_stb", a_vid_rdstb, 0);

    // video keeps requesting from release onward
    rst = 1'b0; t = 0;
    for (int i = 0; i < 4; i++) begin
      goto(i);
      chk("mr_idle_slot", {a_dc_start, a_vid_ack, a_slot_owner}, 0);
    end
    goto(2);  chk("sat_p2", u_c.u_rt.pending, 1);
    goto(4);  chk("mr_first_vid", {a_vid_ack, a_slot_owner}, {1'b1, 2'd2});
    goto(10); chk("sat_p10", u_c.u_rt.pending, 5);
    goto(11); chk("sat_p11", u_c.u_rt.pending, 5);
    goto(12);
    chk("sat_collide", u_c.u_rt.pending, 5);
    chk("sat_rfsh_slot", {c_dc_start, c_dc_rfsh, c_slot_owner}, {1'b1, 1'b1, 2'd3});
    goto(15); chk("sat_rfsh_nostb", c_vid_rdstb, 0);
    goto(16); chk("urg_p16", u_b.u_rt.pending, 1);
    goto(22); chk("sat_p22", u_c.u_rt.pending, 7);
    goto(40); chk("sat_p40", u_c.u_rt.pending, 7);
    goto(63); chk("urg_p63", u_b.u_rt.pending, 3);
    goto(64);
    chk("urg_p64", u_b.u_rt.pending, 4);
    chk("urg_still_vid", b_slot_owner, 2);
    goto(68);
    chk("urg_rfsh", {b_dc_start, b_dc_rfsh, b_vid_ack, b_slot_owner}, {1'b1, 1'b1, 1'b0, 2'd3});
    chk("urg_rfsh_cmd", {b_dc_rnw, b_dc_addr, b_dc_bsel, b_dc_wrdata}, 0);
    chk("urg_p68", u_b.u_rt.pending, 3);
    goto(71); chk("urg_nostb", b_vid_rdstb, 0);
    goto(72); chk("urg_vid_back", {b_vid_ack, b_slot_owner}, {1'b1, 2'd2});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
